// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//   Definitions shared by the serial transmit path: the arbiter state type,
//   the default clock and baud rates that uart_tx is built around, and a small
//   modulo-increment helper used for round-robin pointer arithmetic.
//
//   Contents:
//     CLK_HZ, BAUD_RATE, CLKS_PER_BIT  default timing constants for uart_tx
//     arb_state_t                      uart_tx_arbiter FSM states
//     wrap_inc()                       (value + 1) mod modulus
// -----------------------------------------------------------------------------
package serial_pkg;

   localparam int unsigned CLK_HZ       = 50_000_000;
   localparam int unsigned BAUD_RATE    = 115_200;
   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD_RATE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_HOLD
   } arb_state_t;

   // Increment with wrap-around; modulus need not be a power of two.
   function automatic int unsigned wrap_inc(input int unsigned value,
                                            input int unsigned modulus);
      return ((value + 32'd1) >= modulus) ? 32'd0 : (value + 32'd1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin selector. Starting at position ptr and
//   wrapping past N_REQ-1 back to 0, it grants the first asserted request.
//
//   Ports:
//     req  in   N_REQ   request vector
//     ptr  in   PTR_W   position with highest priority this cycle
//     gnt  out  N_REQ   one-hot grant, all zero when req is zero
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt
);

   // One bit wider than the pointer so ptr + offset never overflows before
   // the wrap is applied.
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;
   logic             found;

   // Walk the candidates in priority order and keep only the first hit.
   always_comb begin
      gnt   = '0;
      sum   = '0;
      idx   = '0;
      found = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         sum = {1'b0, ptr} + (PTR_W + 1)'(off);
         if (sum >= (PTR_W + 1)'(N_REQ)) begin
            sum = sum - (PTR_W + 1)'(N_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx between N_REQ byte-stream requesters. Ownership is
//   granted round-robin and locked for a whole message (until a byte flagged
//   req_last has been transmitted). An owner that stops supplying bytes
//   mid-message for STALL_CLKS clocks loses the lock and stall_err pulses.
//
//   Ports:
//     clk        in   1        system clock
//     rst        in   1        synchronous active-high reset
//     req_valid  in   N_REQ    per-requester byte available
//     req_data   in   N_REQ*8  per-requester byte, requester i at [8i+7:8i]
//     req_last   in   N_REQ    byte is the final byte of its message
//     req_ready  out  N_REQ    one-cycle pulse: owner's byte consumed
//     tx_send    out  1        send strobe to uart_tx
//     tx_data    out  8        byte to uart_tx (holds last byte sent)
//     tx_busy    in   1        uart_tx busy
//     grant      out  N_REQ    one-hot current owner, zero when idle
//     stall_err  out  1        one-cycle pulse when a stalled lock is revoked
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import serial_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int STALL_CLKS = 1_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*8-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_send,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [N_REQ-1:0]   grant,
   output logic               stall_err
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = (STALL_CLKS > 2) ? $clog2(STALL_CLKS) : 1;
   localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CLKS - 1);

   arb_state_t       state, state_d;
   logic [N_REQ-1:0] grant_d;
   logic [PTR_W-1:0] owner, owner_d;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
   logic [PTR_W-1:0] next_ptr;
   logic             last_q, last_d;
   logic [7:0]       data_q, data_d;
   logic [CNT_W-1:0] stall_cnt, stall_cnt_d;

   logic [N_REQ-1:0] pick_gnt;
   logic [PTR_W-1:0] pick_idx;
   logic             owner_valid;
   logic             owner_last;
   logic [7:0]       owner_data;

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt)
   );

   // The picker hands back a one-hot vector; the FSM also needs the index
   // so it can steer the data/valid/last muxes for the locked owner.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) begin
            pick_idx = PTR_W'(i);
         end
      end
   end

   // The owner's request lines, selected by the registered owner index.
   assign owner_valid = req_valid[owner];
   assign owner_last  = req_last[owner];
   assign owner_data  = req_data[{owner, 3'b000} +: 8];

   // Pointer position just past the current owner, used on every release.
   assign next_ptr = PTR_W'(wrap_inc(32'(owner), 32'(N_REQ)));

   // While a byte is being handed over, tx_data shows it directly so uart_tx
   // samples it in the same cycle as tx_send; otherwise it repeats the last
   // byte that was sent.
   assign tx_data = tx_send ? owner_data : data_q;

   // State register and all datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         owner     <= '0;
         rr_ptr    <= '0;
         last_q    <= 1'b0;
         data_q    <= 8'h00;
         stall_cnt <= '0;
      end else begin
         state     <= state_d;
         grant     <= grant_d;
         owner     <= owner_d;
         rr_ptr    <= rr_ptr_d;
         last_q    <= last_d;
         data_q    <= data_d;
         stall_cnt <= stall_cnt_d;
      end
   end

   // Next-state and output decode. Other requesters are only looked at in
   // IDLE, which is what keeps a message's bytes from ever interleaving with
   // another requester's. A byte is only handed over in LOAD with tx_busy low,
   // so a uart_tx still busy from an earlier frame simply delays the hand-off.
   always_comb begin
      state_d     = state;
      grant_d     = grant;
      owner_d     = owner;
      rr_ptr_d    = rr_ptr;
      last_d      = last_q;
      data_d      = data_q;
      stall_cnt_d = stall_cnt;
      tx_send     = 1'b0;
      req_ready   = '0;
      stall_err   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (|req_valid) begin
               grant_d = pick_gnt;
               owner_d = pick_idx;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (!owner_valid) begin
               stall_cnt_d = '0;
               state_d     = ST_HOLD;
            end else if (!tx_busy) begin
               tx_send          = 1'b1;
               req_ready[owner] = 1'b1;
               data_d           = owner_data;
               last_d           = owner_last;
               state_d          = ST_WAIT_BUSY;
            end
         end

         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end
         end

         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q) begin
                  grant_d  = '0;
                  rr_ptr_d = next_ptr;
                  state_d  = ST_IDLE;
               end else begin
                  state_d  = ST_LOAD;
               end
            end
         end

         ST_HOLD: begin
            // A returning byte wins over a revocation due in the same cycle.
            if (owner_valid) begin
               state_d = ST_LOAD;
            end else if (stall_cnt == STALL_LAST) begin
               stall_err = 1'b1;
               grant_d   = '0;
               rr_ptr_d  = next_ptr;
               state_d   = ST_IDLE;
            end else begin
               stall_cnt_d = stall_cnt + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter with four requesters and a short stall timeout.
//   Requester drivers feed bytes from per-requester queues, a uart_tx model
//   holds busy for a set or random frame length, and a scoreboard compares
//   every tx_send against the expected (requester, byte) sequence produced by
//   a message-level round-robin model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int STALL = 16;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         gap;
   } stim_t;

   typedef struct {
      int         req;
      logic [7:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*8-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic           tx_send;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [N-1:0]   grant;
   logic           stall_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int sends  = 0;
   int stalls = 0;
   int m_ptr  = 0;

   int  frame_left = 0;
   int  busy_len   = 10;
   bit  rand_busy  = 1'b0;
   bit  busy_force = 1'b0;

   stim_t        stim  [N][$];
   stim_t        drv_q [N][$];
   int           gap_cnt [N];
   logic [N-1:0] ready_seen = '0;
   exp_t         exp_q [$];
   exp_t         mon_e;
   int           send_cyc [$];

   uart_tx_arbiter #(
      .N_REQ      (N),
      .STALL_CLKS (STALL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_send   (tx_send),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .grant     (grant),
      .stall_err (stall_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: a byte is taken when tx_send=1 and busy=0, busy follows
   // from the next cycle for the frame length; not affected by rst.
   always @(posedge clk) begin
      if (tx_send && !tx_busy) begin
         frame_left <= rand_busy ? int'($urandom_range(12, 1)) : busy_len;
      end else if (frame_left > 0) begin
         frame_left <= frame_left - 1;
      end
   end

   assign tx_busy = busy_force || (frame_left > 0);

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Requester drivers: a consumed byte (req_ready seen mid-cycle) is popped
   // just after the following edge; an entry's gap keeps valid low that long.
   always @(negedge clk) ready_seen = req_ready;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (ready_seen[i]) begin
            if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            if (drv_q[i].size() > 0) gap_cnt[i] = drv_q[i][0].gap;
         end
         if (gap_cnt[i] > 0) begin
            gap_cnt[i]--;
            req_valid[i] = 1'b0;
         end else begin
            req_valid[i] = (drv_q[i].size() > 0);
         end
         if (drv_q[i].size() > 0) begin
            req_data[i*8 +: 8] = drv_q[i][0].data;
            req_last[i]        = drv_q[i][0].last;
         end else begin
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
      ready_seen = '0;
   end

   // Scoreboard monitor: every send is matched against the expected queue.
   always @(negedge clk) begin
      if (!rst && tx_send) begin
         sends++;
         send_cyc.push_back(cyc);
         check_output("send_busy_low", 32'(tx_busy), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_send: got data %0h grant %b, expected no send", tx_data, grant);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("tx_data", 32'(tx_data), 32'(mon_e.data));
            check_output("grant_owner", 32'(grant), 32'(1) << mon_e.req);
            check_output("req_ready", 32'(req_ready), 32'(1) << mon_e.req);
         end
      end
      if (!rst && !tx_send && (req_ready != '0)) begin
         check_output("ready_without_send", 32'(req_ready), 32'd0);
      end
      if (!rst && stall_err) stalls++;
   end

   task automatic add_byte(input int r, input logic [7:0] d, input logic last, input int gap);
      stim_t s;
      s.data = d;
      s.last = last;
      s.gap  = gap;
      stim[r].push_back(s);
   endtask

   // Reference model at message level: whole messages are served round-robin
   // from the pointer, which moves past each served requester. A trailing
   // unterminated message is served once (it ends by stall revocation).
   task automatic apply_stimulus();
      int  pos [N];
      int  r;
      int  c;
      bit  fin;
      exp_t e;
      for (int i = 0; i < N; i++) pos[i] = 0;
      fin = 1'b0;
      while (!fin) begin
         r = -1;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (r < 0 && pos[c] < stim[c].size()) r = c;
         end
         if (r < 0) begin
            fin = 1'b1;
         end else begin
            do begin
               e.req  = r;
               e.data = stim[r][pos[r]].data;
               exp_q.push_back(e);
               pos[r]++;
            end while (pos[r] < stim[r].size() && !stim[r][pos[r]-1].last);
            m_ptr = (r + 1) % N;
         end
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         foreach (stim[i][j]) drv_q[i].push_back(stim[i][j]);
         stim[i].delete();
      end
   endtask

   task automatic apply_reset(input bit do_check);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         drv_q[i].delete();
         gap_cnt[i] = 0;
      end
      @(negedge clk);
      if (do_check) begin
         check_output("rst_grant", 32'(grant), 32'd0);
         check_output("rst_tx_send", 32'(tx_send), 32'd0);
         check_output("rst_tx_data", 32'(tx_data), 32'd0);
         check_output("rst_req_ready", 32'(req_ready), 32'd0);
         check_output("rst_stall_err", 32'(stall_err), 32'd0);
      end
      rst   = 1'b0;
      m_ptr = 0;
   endtask

   function automatic bit drivers_empty();
      for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   // Wait for all expected bytes sent and the uart idle, then confirm the
   // lock is released.
   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (n < budget && !(exp_q.size() == 0 && drivers_empty() && !tx_busy)) begin
         @(negedge clk);
         n++;
      end
      check_output({name, "_done_in_time"}, 32'(n < budget), 32'd1);
      repeat (2) @(negedge clk);
      check_output({name, "_grant_released"}, 32'(grant), 32'd0);
   endtask

   initial begin
      int n;
      int base_send;
      int base_stall;
      int stall_at;

      // Reset state.
      apply_reset(1'b1);

      // uart busy at power-up while requester 1 is waiting.
      @(posedge clk);
      #1;
      busy_force = 1'b1;
      add_byte(1, 8'h5A, 1'b1, 0);
      apply_stimulus();
      repeat (3) @(posedge clk);
      #1;
      check_output("no_send_while_busy", 32'(sends), 32'd0);
      busy_force = 1'b0;
      wait_idle("powerup_busy", 200);

      // "Hi" from requester 0 with a 10-clock frame.
      busy_len = 10;
      add_byte(0, 8'h48, 1'b0, 0);
      add_byte(0, 8'h69, 1'b1, 0);
      apply_stimulus();
      wait_idle("hi", 400);

      // Requesters 0 and 2 from reset: whole messages, no interleave.
      apply_reset(1'b0);
      rand_busy = 1'b1;
      add_byte(0, 8'h01, 1'b0, 0);
      add_byte(0, 8'h02, 1'b0, 2);
      add_byte(0, 8'h03, 1'b1, 0);
      add_byte(2, 8'h21, 1'b0, 0);
      add_byte(2, 8'h22, 1'b1, 3);
      apply_stimulus();
      wait_idle("two_req", 600);

      // All four requesters with one-byte messages: order 0,1,2,3,0,...
      apply_reset(1'b0);
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < N; r++) add_byte(r, 8'(8'h80 + r * 16 + m), 1'b1, 0);
      end
      apply_stimulus();
      wait_idle("round_robin", 800);

      // Stall: requester 0 abandons its message after one byte.
      apply_reset(1'b0);
      rand_busy  = 1'b0;
      busy_len   = 10;
      base_send  = send_cyc.size();
      base_stall = stalls;
      add_byte(0, 8'hA1, 1'b0, 0);
      add_byte(1, 8'hB1, 1'b1, 0);
      apply_stimulus();
      n = 0;
      while (n < 300 && stall_err !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      stall_at = cyc;
      check_output("stall_seen", 32'(n < 300), 32'd1);
      if (send_cyc.size() > base_send) begin
         check_output("stall_timing", 32'(stall_at), 32'(send_cyc[base_send] + busy_len + 2 + STALL));
      end else begin
         check_output("stall_first_byte_sent", 32'(send_cyc.size()), 32'(base_send + 1));
      end
      @(negedge clk);
      check_output("stall_grant_cleared", 32'(grant), 32'd0);
      wait_idle("stall", 400);
      check_output("stall_pulse_count", 32'(stalls - base_stall), 32'd1);

      // Reset while waiting for the first frame of a two-byte message.
      apply_reset(1'b0);
      add_byte(2, 8'hC1, 1'b0, 0);
      add_byte(2, 8'hC2, 1'b1, 0);
      apply_stimulus();
      void'(exp_q.pop_back());
      n = 0;
      while (n < 100 && exp_q.size() != 0) begin
         @(negedge clk);
         n++;
      end
      check_output("c1_sent", 32'(n < 100), 32'd1);
      repeat (3) @(negedge clk);
      base_send = sends;
      apply_reset(1'b1);
      repeat (30) @(negedge clk);
      check_output("no_send_after_reset", 32'(sends), 32'(base_send));
      add_byte(3, 8'hD3, 1'b1, 0);
      apply_stimulus();
      wait_idle("after_reset", 300);

      // Randomized rounds checked against the message-level model.
      rand_busy = 1'b1;
      for (int round = 0; round < 6; round++) begin
         int nmsg;
         int len;
         for (int r = 0; r < N; r++) begin
            nmsg = int'($urandom_range(3, 0));
            for (int m = 0; m < nmsg; m++) begin
               len = int'($urandom_range(4, 1));
               for (int b = 0; b < len; b++) begin
                  add_byte(r, 8'($urandom), (b == len - 1),
                           (b == 0) ? 0 : int'($urandom_range(6, 0)));
               end
            end
         end
         apply_stimulus();
         wait_idle("random", 3000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
